// File: rtl/mac4_accumulator.sv
// Multiply-accumulate controller wrapped around an external combinational 4x4 multiplier.
// Sums BLOCK_LEN products per result; results leave over a valid/ready handshake with a sticky overflow flag.
module mac4_accumulator #(
    parameter int ACC_W     = 12,
    parameter int BLOCK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    output logic [3:0]       mul_x,
    output logic [3:0]       mul_y,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] BL     = 4'(BLOCK_LEN);

    logic [1:0]       r_state;
    logic [3:0]       r_issued;
    logic [3:0]       r_summed;
    logic             r_p_vld;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [3:0]       r_mul_x;
    logic [3:0]       r_mul_y;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_ovf;

    logic             w_accept;
    logic             w_last;
    logic [ACC_W:0]   w_sum;

    assign in_ready  = (r_state != S_DONE) && (r_issued < BL);
    assign w_accept  = in_valid && in_ready;
    // Extra top bit of the sum is the carry out of this addition.
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, mul_p};
    assign w_last    = r_p_vld && (r_summed == BL - 4'd1);

    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

    // Operand registers keep their value through clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_x <= 4'd0;
            r_mul_y <= 4'd0;
        end else if (w_accept && !clear) begin
            r_mul_x <= in_x;
            r_mul_y <= in_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_issued    <= 4'd0;
            r_summed    <= 4'd0;
            r_p_vld     <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_issued    <= 4'd0;
            r_summed    <= 4'd0;
            r_p_vld     <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_p_vld <= w_accept;
            if (w_accept)
                r_issued <= r_issued + 4'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    // mul_p is only looked at when a product is actually pending.
                    if (r_p_vld) begin
                        r_acc    <= w_sum[ACC_W-1:0];
                        r_ovf    <= r_ovf | w_sum[ACC_W];
                        r_summed <= r_summed + 4'd1;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_acc   <= w_sum[ACC_W-1:0];
                            r_out_ovf   <= r_ovf | w_sum[ACC_W];
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_issued    <= 4'd0;
                        r_summed    <= 4'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac4_accumulator.sv
// Bench for mac4_accumulator: three configurations (12/4, 8/2, 12/1) checked every cycle
// against an integer-sum model, plus directed scenarios with hand-computed results.
module tb_mac4_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_x = 4'd0;
    logic [3:0] in_y = 4'd0;
    logic [2:0] en = 3'b000;

    logic        rdy [3];
    logic        ovl [3];
    logic        ovf [3];
    logic [15:0] oacc [3];
    logic [3:0]  mx [3];
    logic [3:0]  my [3];
    logic [7:0]  mp [3];
    logic [11:0] a0;
    logic [7:0]  a1;
    logic [11:0] a2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mp[0] = mx[0] * my[0];
    assign mp[1] = mx[1] * my[1];
    assign mp[2] = mx[2] * my[2];
    assign oacc[0] = {4'd0, a0};
    assign oacc[1] = {8'd0, a1};
    assign oacc[2] = {4'd0, a2};

    mac4_accumulator #(.ACC_W(12), .BLOCK_LEN(4)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid && en[0]), .in_ready(rdy[0]),
        .in_x(in_x), .in_y(in_y), .mul_x(mx[0]), .mul_y(my[0]), .mul_p(mp[0]),
        .out_valid(ovl[0]), .out_ready(out_ready), .out_acc(a0), .out_ovf(ovf[0]));

    mac4_accumulator #(.ACC_W(8), .BLOCK_LEN(2)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid && en[1]), .in_ready(rdy[1]),
        .in_x(in_x), .in_y(in_y), .mul_x(mx[1]), .mul_y(my[1]), .mul_p(mp[1]),
        .out_valid(ovl[1]), .out_ready(out_ready), .out_acc(a1), .out_ovf(ovf[1]));

    mac4_accumulator #(.ACC_W(12), .BLOCK_LEN(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid && en[2]), .in_ready(rdy[2]),
        .in_x(in_x), .in_y(in_y), .mul_x(mx[2]), .mul_y(my[2]), .mul_p(mp[2]),
        .out_valid(ovl[2]), .out_ready(out_ready), .out_acc(a2), .out_ovf(ovf[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: count accepted/summed pairs, keep the exact (unbounded) block total.
    int    W [3] = '{12, 8, 12};
    int    L [3] = '{4, 2, 1};
    int    m_acc [3];
    int    m_sum [3];
    longint m_tot [3];
    bit    m_pend [3];
    int    m_pp [3];
    bit    m_vld [3];
    longint m_racc [3];
    bit    m_rovf [3];
    bit    e_rdy, fire;

    task automatic model_reset(input int k);
        m_acc[k] = 0; m_sum[k] = 0; m_tot[k] = 0; m_pend[k] = 0; m_pp[k] = 0;
        m_vld[k] = 0; m_racc[k] = 0; m_rovf[k] = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) model_reset(k);
        end else begin
            for (int k = 0; k < 3; k++) begin
                e_rdy = !m_vld[k] && (m_acc[k] < L[k]);
                fire  = in_valid && en[k] && e_rdy;
                if (clear) begin
                    model_reset(k);
                end else begin
                    if (m_pend[k]) begin
                        m_tot[k] += m_pp[k];
                        m_sum[k]++;
                        if (m_sum[k] == L[k]) begin
                            m_vld[k]  = 1;
                            m_racc[k] = m_tot[k] % (longint'(1) << W[k]);
                            m_rovf[k] = m_tot[k] >= (longint'(1) << W[k]);
                        end
                    end else if (m_vld[k] && out_ready) begin
                        m_vld[k] = 0; m_acc[k] = 0; m_sum[k] = 0; m_tot[k] = 0;
                    end
                    m_pend[k] = fire;
                    if (fire) begin
                        m_pp[k] = int'(in_x) * int'(in_y);
                        m_acc[k]++;
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.in_ready", k), rdy[k], !m_vld[k] && (m_acc[k] < L[k]));
            chk($sformatf("u%0d.out_valid", k), ovl[k], m_vld[k]);
            chk($sformatf("u%0d.out_acc", k), oacc[k], m_racc[k][31:0]);
            chk($sformatf("u%0d.out_ovf", k), ovf[k], m_rovf[k]);
        end
    end

    task automatic wait_vld(input int k, input int bound);
        int n = 0;
        while (ovl[k] !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d.wait_out_valid", k), ovl[k], 1);
    endtask

    task automatic drive_pairs(input int n, input logic [3:0] x, input logic [3:0] y);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_x = x; in_y = y;
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    logic [3:0] t1x [4] = '{4'd3, 4'd15, 4'd0, 4'd7};
    logic [3:0] t1y [4] = '{4'd5, 4'd15, 4'd9, 4'd2};
    bit         gap [7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        en = 3'b001;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", rdy[0], 1);
        chk("reset.out_valid", ovl[0], 0);
        chk("reset.out_acc", oacc[0], 0);
        chk("reset.mul_x", mx[0], 0);
        rst_n = 1;
        @(negedge clk);

        // Back-to-back block, downstream always ready.
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_x = t1x[i]; in_y = t1y[i];
            @(negedge clk);
        end
        in_valid = 0;
        chk("t1.in_ready_low", rdy[0], 0);
        chk("t1.not_yet_valid", ovl[0], 0);
        @(negedge clk);
        chk("t1.out_valid", ovl[0], 1);
        chk("t1.out_acc", oacc[0], 254);
        chk("t1.out_ovf", ovf[0], 0);
        @(negedge clk);
        chk("t1.one_cycle_pulse", ovl[0], 0);
        chk("t1.in_ready_back", rdy[0], 1);

        // Same block, result held back for 10 cycles while input keeps offering.
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_x = t1x[i]; in_y = t1y[i];
            @(negedge clk);
        end
        in_x = 4'd9; in_y = 4'd9;
        wait_vld(0, 5);
        repeat (10) @(negedge clk);
        chk("t2.held_valid", ovl[0], 1);
        chk("t2.held_acc", oacc[0], 254);
        chk("t2.held_in_ready", rdy[0], 0);
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        chk("t2.handshake_valid_low", ovl[0], 0);
        chk("t2.in_ready_after", rdy[0], 1);

        // Gapped input, all (15,15).
        for (int i = 0; i < 7; i++) begin
            in_valid = gap[i]; in_x = 4'd15; in_y = 4'd15;
            @(negedge clk);
        end
        in_valid = 0;
        wait_vld(0, 5);
        chk("t3.out_acc", oacc[0], 900);
        chk("t3.out_ovf", ovf[0], 0);
        @(negedge clk);

        // 8-bit accumulator wraps, then a clean block.
        en = 3'b010;
        drive_pairs(2, 4'd15, 4'd15);
        wait_vld(1, 5);
        chk("t4.wrap_acc", oacc[1], 194);
        chk("t4.wrap_ovf", ovf[1], 1);
        @(negedge clk);
        drive_pairs(2, 4'd1, 4'd1);
        wait_vld(1, 5);
        chk("t4.next_acc", oacc[1], 2);
        chk("t4.next_ovf", ovf[1], 0);
        @(negedge clk);

        // Clear after two accepts, with an accept offered in the clear cycle.
        en = 3'b001;
        drive_pairs(2, 4'd9, 4'd9);
        in_valid = 1; clear = 1;
        @(negedge clk);
        in_valid = 0; clear = 0;
        chk("t5.clear_valid", ovl[0], 0);
        chk("t5.clear_in_ready", rdy[0], 1);
        chk("t5.clear_acc", oacc[0], 0);
        drive_pairs(4, 4'd2, 4'd3);
        wait_vld(0, 5);
        chk("t5.out_acc", oacc[0], 24);
        @(negedge clk);

        // Asynchronous reset while a result is being held.
        out_ready = 0;
        drive_pairs(4, 4'd15, 4'd15);
        wait_vld(0, 5);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("t6.async_valid", ovl[0], 0);
        chk("t6.async_acc", oacc[0], 0);
        chk("t6.async_in_ready", rdy[0], 1);
        chk("t6.async_mul_x", mx[0], 0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        en = 3'b100;
        in_valid = 1; in_x = 4'd4; in_y = 4'd4;
        @(negedge clk);
        in_valid = 0;
        chk("t6.bl1_not_yet", ovl[2], 0);
        @(negedge clk);
        chk("t6.bl1_valid", ovl[2], 1);
        chk("t6.bl1_acc", oacc[2], 16);
        @(negedge clk);

        // Random traffic on all three instances.
        en = 3'b111;
        repeat (1500) begin
            in_valid  = ($urandom % 4) != 0;
            in_x      = 4'($urandom);
            in_y      = 4'($urandom);
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 40) == 0;
            @(negedge clk);
        end
        in_valid = 0; clear = 0; out_ready = 1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
